// File: rtl/xm23_pkg.sv
// Shared types and constants for the XM23 instruction-fetch path.
package xm23_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_MEM   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_t;

  // Memory control: [0] enable, [1] R/W (0 = read), [2] byte (1) / word (0)
  localparam logic [2:0]  CTRL_RD_WORD = 3'b001;
  localparam logic [2:0]  CTRL_IDLE    = 3'b000;

  localparam logic [15:0] PC_STEP      = 16'd2;

endpackage

// File: rtl/xm23_fetch_unit.sv
// XM23 instruction-fetch sequencer: PC, MAR/CTRL word reads, IR capture,
// decoder handshake, run/step mode, sleep and breakpoint handling.
module xm23_fetch_unit
  import xm23_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic        Step,
  input  logic        Slp,
  input  logic [15:0] Bkpnt,
  input  logic        Bkpnt_en,
  input  logic [15:0] Pc_in,
  input  logic        Pc_load,
  input  logic        Exec_done,
  input  logic [15:0] Mdr,
  output logic [15:0] Mar,
  output logic [2:0]  Ctrl,
  output logic [15:0] Instr,
  output logic        Instr_valid,
  output logic [15:0] Pc,
  output logic        Halted,
  output logic        Fault
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1) + 1;

  fetch_state_t     state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             step_pend, step_pend_d;
  logic             bp_skip, bp_skip_d;
  logic [15:0]      mar_d, instr_d, pc_d;
  logic [2:0]       ctrl_d;
  logic             instr_valid_d, halted_d, fault_d;

  // State and registered outputs
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      step_pend   <= 1'b0;
      bp_skip     <= 1'b0;
      Mar         <= 16'h0000;
      Ctrl        <= CTRL_IDLE;
      Instr       <= 16'h0000;
      Instr_valid <= 1'b0;
      Pc          <= RESET_PC;
      Halted      <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      step_pend   <= step_pend_d;
      bp_skip     <= bp_skip_d;
      Mar         <= mar_d;
      Ctrl        <= ctrl_d;
      Instr       <= instr_d;
      Instr_valid <= instr_valid_d;
      Pc          <= pc_d;
      Halted      <= halted_d;
      Fault       <= fault_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    step_pend_d   = step_pend;
    bp_skip_d     = bp_skip;
    mar_d         = Mar;
    ctrl_d        = Ctrl;
    instr_d       = Instr;
    instr_valid_d = Instr_valid;
    pc_d          = Pc;
    halted_d      = Halted;
    fault_d       = Fault;

    // A step request is latched until the fetch it starts leaves IDLE
    if (Step && !Run && (state != ST_HALT)) begin
      step_pend_d = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        // A PC load wins over starting a fetch from the stale PC
        if (Pc_load) begin
          pc_d = Pc_in;
        end else if (!Slp && (Run || step_pend)) begin
          if (Bkpnt_en && (Pc == Bkpnt) && !bp_skip) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (Pc[0]) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d     = ST_ADDR;
            mar_d       = Pc;
            ctrl_d      = CTRL_RD_WORD;
            step_pend_d = 1'b0;
            bp_skip_d   = 1'b0;
          end
        end
      end

      ST_ADDR: begin
        ctrl_d  = CTRL_IDLE;
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = ST_MEM;
      end

      ST_MEM: begin
        if (cnt == CNT_W'(1)) begin
          instr_d       = Mdr;
          pc_d          = Pc + PC_STEP;
          instr_valid_d = 1'b1;
          state_d       = ST_ISSUE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      ST_ISSUE: begin
        if (Exec_done) begin
          instr_valid_d = 1'b0;
          state_d       = ST_IDLE;
          if (Pc_load) begin
            pc_d = Pc_in;
          end
        end
      end

      ST_HALT: begin
        if (Pc_load) begin
          pc_d = Pc_in;
        end
        if (Step) begin
          bp_skip_d   = 1'b1;
          step_pend_d = 1'b1;
          halted_d    = 1'b0;
          state_d     = ST_IDLE;
        end else if (!Bkpnt_en || Pc_load) begin
          halted_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      ST_FAULT: begin
        if (Pc_load) begin
          fault_d = 1'b0;
          pc_d    = Pc_in;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_xm23_fetch_unit.sv
// Directed bench for xm23_fetch_unit with a byte-addressed memory model.
module tb_xm23_fetch_unit;

  logic        Clock;
  logic        Reset_n;
  logic        Run;
  logic        Step;
  logic        Slp;
  logic [15:0] Bkpnt;
  logic        Bkpnt_en;
  logic [15:0] Pc_in;
  logic        Pc_load;
  logic        Exec_done;
  logic [15:0] Mdr;
  logic [15:0] Mar;
  logic [2:0]  Ctrl;
  logic [15:0] Instr;
  logic        Instr_valid;
  logic [15:0] Pc;
  logic        Halted;
  logic        Fault;

  int n_checks;
  int n_err;
  int en_cnt;
  int base;

  logic [7:0] mem [0:65535];

  xm23_fetch_unit #(.RESET_PC(16'h0000), .MEM_LAT(1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Step(Step), .Slp(Slp),
    .Bkpnt(Bkpnt), .Bkpnt_en(Bkpnt_en), .Pc_in(Pc_in), .Pc_load(Pc_load),
    .Exec_done(Exec_done), .Mdr(Mdr), .Mar(Mar), .Ctrl(Ctrl), .Instr(Instr),
    .Instr_valid(Instr_valid), .Pc(Pc), .Halted(Halted), .Fault(Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory: a read enable seen at an edge returns the little-endian word
  always @(posedge Clock) begin
    if (Ctrl[0] && !Ctrl[1]) begin
      Mdr <= {mem[16'(Mar + 16'd1)], mem[Mar]};
    end
  end

  // Count cycles with the memory enable high
  always @(posedge Clock) begin
    if (Reset_n && Ctrl[0]) en_cnt++;
  end

  typedef struct {
    logic        run;
    logic        exec_done;
    logic [2:0]  ctrl;
    logic [15:0] mar;
    logic [15:0] instr;
    logic        iv;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic defaults();
    Run = 1'b0; Step = 1'b0; Slp = 1'b0; Bkpnt = 16'h0; Bkpnt_en = 1'b0;
    Pc_in = 16'h0; Pc_load = 1'b0; Exec_done = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    defaults();
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic step_pulse();
    Step = 1'b1;
    tick();
    Step = 1'b0;
  endtask

  // sel: 0 = Instr_valid, 1 = Halted, 2 = Ctrl[0]
  task automatic wait_for(input int sel, input int budget, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((sel == 0 && Instr_valid) || (sel == 1 && Halted) || (sel == 2 && Ctrl[0])) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 16'(got), 16'd1);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    en_cnt   = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h4C; mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'h07; mem[16'h0003] = 8'h68;
    mem[16'h0004] = 8'h5A; mem[16'h0005] = 8'hA5;
    mem[16'h0100] = 8'hAD; mem[16'h0101] = 8'hDE;
    mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h12;

    vecs[0] = '{1'b1, 1'b1, 3'b001, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 3'b000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 3'b000, 16'h0000, 16'h124C, 1'b1, 16'h0002};
    vecs[3] = '{1'b1, 1'b1, 3'b000, 16'h0000, 16'h124C, 1'b0, 16'h0002};
    vecs[4] = '{1'b1, 1'b1, 3'b001, 16'h0002, 16'h124C, 1'b0, 16'h0002};
    vecs[5] = '{1'b1, 1'b1, 3'b000, 16'h0002, 16'h124C, 1'b0, 16'h0002};
    vecs[6] = '{1'b1, 1'b1, 3'b000, 16'h0002, 16'h6807, 1'b1, 16'h0004};
    vecs[7] = '{1'b1, 1'b1, 3'b000, 16'h0002, 16'h6807, 1'b0, 16'h0004};

    // Reset values
    do_reset();
    chk("rst_mar", Mar, 16'h0000);
    chk("rst_ctrl", 16'(Ctrl), 16'h0000);
    chk("rst_instr", Instr, 16'h0000);
    chk("rst_iv", 16'(Instr_valid), 16'h0000);
    chk("rst_pc", Pc, 16'h0000);
    chk("rst_halted", 16'(Halted), 16'h0000);
    chk("rst_fault", 16'(Fault), 16'h0000);

    // Continuous run, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      Run = vecs[i].run;
      Exec_done = vecs[i].exec_done;
      tick();
      chk($sformatf("tbl%0d_ctrl", i), 16'(Ctrl), 16'(vecs[i].ctrl));
      chk($sformatf("tbl%0d_mar", i), Mar, vecs[i].mar);
      chk($sformatf("tbl%0d_instr", i), Instr, vecs[i].instr);
      chk($sformatf("tbl%0d_iv", i), 16'(Instr_valid), 16'(vecs[i].iv));
      chk($sformatf("tbl%0d_pc", i), Pc, vecs[i].pc);
    end

    // Step mode: two pulses, two fetches
    do_reset();
    Exec_done = 1'b1;
    base = en_cnt;
    step_pulse();
    repeat (20) tick();
    chk("step1_pc", Pc, 16'h0002);
    chk("step1_instr", Instr, 16'h124C);
    step_pulse();
    repeat (20) tick();
    chk("step2_pc", Pc, 16'h0004);
    chk("step2_instr", Instr, 16'h6807);
    chk("step_en_pulses", 16'(en_cnt - base), 16'd2);

    // Breakpoint at 0x0004, step over it, then hit it again
    do_reset();
    Bkpnt = 16'h0004; Bkpnt_en = 1'b1; Run = 1'b1; Exec_done = 1'b1;
    base = en_cnt;
    wait_for(1, 40, "bp_wait_halt");
    chk("bp_pc", Pc, 16'h0004);
    chk("bp_en_pulses", 16'(en_cnt - base), 16'd2);
    Exec_done = 1'b0;
    step_pulse();
    chk("bp_step_unhalt", 16'(Halted), 16'h0000);
    wait_for(0, 20, "bp_wait_valid");
    chk("bp_step_instr", Instr, 16'hA55A);
    chk("bp_step_pc", Pc, 16'h0006);
    Pc_load = 1'b1; Pc_in = 16'h0004; Exec_done = 1'b1;
    tick();
    Pc_load = 1'b0;
    wait_for(1, 10, "bp_wait_rehalt");
    chk("bp_rehalt_pc", Pc, 16'h0004);
    chk("bp_rehalt_en", 16'(en_cnt - base), 16'd3);

    // Odd PC fault and recovery
    do_reset();
    Pc_load = 1'b1; Pc_in = 16'h0101; Exec_done = 1'b1;
    tick();
    Pc_load = 1'b0;
    base = en_cnt;
    Run = 1'b1;
    repeat (10) tick();
    chk("fault_set", 16'(Fault), 16'h0001);
    chk("fault_no_fetch", 16'(en_cnt - base), 16'd0);
    chk("fault_pc", Pc, 16'h0101);
    Pc_load = 1'b1; Pc_in = 16'h0100;
    tick();
    Pc_load = 1'b0;
    chk("fault_clear", 16'(Fault), 16'h0000);
    chk("fault_reload_pc", Pc, 16'h0100);
    wait_for(0, 20, "fault_wait_valid");
    chk("fault_resume_instr", Instr, 16'hDEAD);
    chk("fault_resume_pc", Pc, 16'h0102);

    // Sleep raised mid-fetch
    do_reset();
    Run = 1'b1; Exec_done = 1'b1;
    base = en_cnt;
    wait_for(2, 10, "slp_wait_addr");
    tick();
    Slp = 1'b1;
    wait_for(0, 10, "slp_wait_valid");
    chk("slp_instr", Instr, 16'h124C);
    repeat (10) tick();
    chk("slp_en_pulses", 16'(en_cnt - base), 16'd1);
    chk("slp_pc", Pc, 16'h0002);
    chk("slp_iv", 16'(Instr_valid), 16'h0000);
    Slp = 1'b0;
    wait_for(0, 10, "slp_wait_resume");
    chk("slp_resume_instr", Instr, 16'h6807);
    chk("slp_resume_pc", Pc, 16'h0004);

    // PC wrap
    do_reset();
    Pc_load = 1'b1; Pc_in = 16'hFFFE; Exec_done = 1'b1;
    tick();
    Pc_load = 1'b0;
    step_pulse();
    wait_for(0, 20, "wrap_wait_valid");
    chk("wrap_instr", Instr, 16'h1234);
    chk("wrap_pc", Pc, 16'h0000);

    // Reset during ADDR drops the enable at once
    do_reset();
    Run = 1'b1; Exec_done = 1'b1;
    wait_for(2, 10, "rst_addr_wait");
    Reset_n = 1'b0;
    #1;
    chk("rst_addr_ctrl", 16'(Ctrl), 16'h0000);

    // Reset during MEM of the second fetch
    do_reset();
    Run = 1'b1; Exec_done = 1'b1;
    base = en_cnt;
    for (int i = 0; i < 20; i++) begin
      if (en_cnt - base >= 2) break;
      tick();
    end
    chk("rst_mem_reached", 16'(en_cnt - base), 16'd2);
    chk("rst_mem_pre_pc", Pc, 16'h0002);
    Reset_n = 1'b0;
    #1;
    chk("rst_mem_ctrl", 16'(Ctrl), 16'h0000);
    chk("rst_mem_iv", 16'(Instr_valid), 16'h0000);
    chk("rst_mem_pc", Pc, 16'h0000);
    chk("rst_mem_instr", Instr, 16'h0000);
    tick();
    chk("rst_mem_hold_iv", 16'(Instr_valid), 16'h0000);
    chk("rst_mem_hold_instr", Instr, 16'h0000);
    Reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
